// File: rtl/mux_pkg.sv
// Shared constants and select type for the 8-to-1 lane selector.
// Lane count and select width are fixed; only the lane width is a parameter of the top.
package mux_pkg;
  localparam int N_LANES = 8;
  localparam int SEL_W   = 3;

  typedef logic [SEL_W-1:0] sel_t;
endpackage

// File: rtl/mux_onehot_dec.sv
// 3-to-8 one-hot decoder driving the lane gates of the 8-to-1 selector.
// Every select code maps to exactly one asserted bit, so the output is never all-zero.
module mux_onehot_dec
  import mux_pkg::*;
(
  input  sel_t               i_sel,
  output logic [N_LANES-1:0] o_onehot
);

  always_comb begin
    o_onehot = '0;
    for (int k = 0; k < N_LANES; k++) begin
      o_onehot[k] = (i_sel == sel_t'(k));
    end
  end

endmodule

// File: rtl/multiplexer_8x1.sv
// 8-to-1 lane selector with a combinational output and an enabled register copy.
// Lane k of d sits at d[k*W +: W] and is chosen by select code k.
module multiplexer_8x1
  import mux_pkg::*;
#(
  parameter int W = 1
)
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic [SEL_W-1:0]     s,
  input  logic [N_LANES*W-1:0] d,
  input  logic                 en,
  output logic [W-1:0]         y,
  output logic [W-1:0]         y_q,
  output logic                 y_q_valid
);

  logic [N_LANES-1:0] w_onehot;
  logic [W-1:0]       w_y;
  logic [W-1:0]       r_y_q;
  logic               r_valid;

  mux_onehot_dec u_dec (
    .i_sel    (s),
    .o_onehot (w_onehot)
  );

  // AND-OR selection: exactly one lane gate is open for any select code.
  always_comb begin
    w_y = '0;
    for (int k = 0; k < N_LANES; k++) begin
      w_y = w_y | (d[k*W +: W] & {W{w_onehot[k]}});
    end
  end

  // Reset wins over en, so a capture on a reset edge is dropped.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_y_q   <= '0;
      r_valid <= 1'b0;
    end else if (en) begin
      r_y_q   <= w_y;
      r_valid <= 1'b1;
    end
  end

  assign y         = w_y;
  assign y_q       = r_y_q;
  assign y_q_valid = r_valid;

endmodule

// File: tb/tb_multiplexer_8x1.sv
// Self-checking bench for multiplexer_8x1 using W=1, W=8 and W=4 instances.
// Registered-path expectations are queued when stimulus is applied and popped after the edge.
module tb_multiplexer_8x1;

  typedef struct {
    logic [7:0] q;
    logic       v;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  logic clk;

  logic       rst1, en1, y1, yq1, v1;
  logic [2:0] s1;
  logic [7:0] d1;

  logic        rst8, en8, v8;
  logic [2:0]  s8;
  logic [63:0] d8;
  logic [7:0]  y8, yq8;

  logic        rst4, en4, v4;
  logic [2:0]  s4;
  logic [31:0] d4;
  logic [3:0]  y4, yq4;

  multiplexer_8x1 #(.W(1)) u_dut1 (
    .clk(clk), .rst(rst1), .s(s1), .d(d1), .en(en1),
    .y(y1), .y_q(yq1), .y_q_valid(v1)
  );

  multiplexer_8x1 #(.W(8)) u_dut8 (
    .clk(clk), .rst(rst8), .s(s8), .d(d8), .en(en8),
    .y(y8), .y_q(yq8), .y_q_valid(v8)
  );

  multiplexer_8x1 #(.W(4)) u_dut4 (
    .clk(clk), .rst(rst4), .s(s4), .d(d4), .en(en4),
    .y(y4), .y_q(yq4), .y_q_valid(v4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic test_reset();
    rst1 = 1'b1; rst8 = 1'b1; rst4 = 1'b1;
    en1 = 1'b0;  en8 = 1'b0;  en4 = 1'b0;
    s1 = '0; s8 = '0; s4 = '0;
    d1 = '0; d8 = '0; d4 = '0;
    @(posedge clk);
    @(posedge clk);
    #1;
    checks++; if (yq1 !== 1'b0) begin errors++; $display("FAIL reset_yq_w1: got %h expected 0", yq1); end
    checks++; if (v1 !== 1'b0)  begin errors++; $display("FAIL reset_valid_w1: got %b expected 0", v1); end
    checks++; if (yq8 !== 8'h00) begin errors++; $display("FAIL reset_yq_w8: got %h expected 00", yq8); end
    checks++; if (v8 !== 1'b0)  begin errors++; $display("FAIL reset_valid_w8: got %b expected 0", v8); end
    checks++; if (yq4 !== 4'h0) begin errors++; $display("FAIL reset_yq_w4: got %h expected 0", yq4); end
    checks++; if (v4 !== 1'b0)  begin errors++; $display("FAIL reset_valid_w4: got %b expected 0", v4); end
    @(negedge clk);
    rst1 = 1'b0; rst8 = 1'b0; rst4 = 1'b0;
  endtask

  task automatic test_fa_sum();
    logic exp_sum [8] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    d1 = 8'b10010110;
    for (int i = 0; i < 8; i++) begin
      s1 = 3'(i);
      #1;
      checks++;
      if (y1 !== exp_sum[i]) begin
        errors++; $display("FAIL fa_sum s=%0d: got %b expected %b", i, y1, exp_sum[i]);
      end
      #9;
    end
  endtask

  task automatic test_fa_carry();
    logic exp_cy [8] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
    d1 = 8'b11101000;
    for (int i = 0; i < 8; i++) begin
      s1 = 3'(i);
      #1;
      checks++;
      if (y1 !== exp_cy[i]) begin
        errors++; $display("FAIL fa_carry s=%0d: got %b expected %b", i, y1, exp_cy[i]);
      end
      #9;
    end
  endtask

  task automatic test_capture_w8();
    exp_t e;
    @(negedge clk);
    for (int k = 0; k < 8; k++) d8[k*8 +: 8] = 8'(8'hA0 + k);
    s8  = 3'd5;
    en8 = 1'b1;
    #1;
    checks++; if (y8 !== 8'hA5) begin errors++; $display("FAIL w8_comb: got %h expected a5", y8); end
    checks++; if (v8 !== 1'b0)  begin errors++; $display("FAIL w8_valid_before_edge: got %b expected 0", v8); end
    sb.push_back('{8'hA5, 1'b1});
    @(posedge clk);
    #1;
    e = sb.pop_front();
    checks++; if (yq8 !== e.q) begin errors++; $display("FAIL w8_capture_yq: got %h expected %h", yq8, e.q); end
    checks++; if (v8 !== e.v)  begin errors++; $display("FAIL w8_capture_valid: got %b expected %b", v8, e.v); end
    @(negedge clk);
    en8 = 1'b0;
  endtask

  task automatic test_reset_priority();
    exp_t e;
    @(negedge clk);
    d1 = 8'b00001000; s1 = 3'd3; en1 = 1'b1;
    sb.push_back('{8'h01, 1'b1});
    @(posedge clk);
    #1;
    e = sb.pop_front();
    checks++; if ({7'b0, yq1} !== e.q) begin errors++; $display("FAIL prio_precapture_yq: got %b expected %h", yq1, e.q); end
    checks++; if (v1 !== e.v) begin errors++; $display("FAIL prio_precapture_valid: got %b expected %b", v1, e.v); end
    @(negedge clk);
    rst1 = 1'b1; en1 = 1'b1;
    #1;
    checks++; if (y1 !== 1'b1) begin errors++; $display("FAIL prio_y_during_rst: got %b expected 1", y1); end
    sb.push_back('{8'h00, 1'b0});
    @(posedge clk);
    #1;
    e = sb.pop_front();
    checks++; if ({7'b0, yq1} !== e.q) begin errors++; $display("FAIL prio_yq: got %b expected %h", yq1, e.q); end
    checks++; if (v1 !== e.v) begin errors++; $display("FAIL prio_valid: got %b expected %b", v1, e.v); end
    checks++; if (y1 !== 1'b1) begin errors++; $display("FAIL prio_y_after_rst: got %b expected 1", y1); end
    @(negedge clk);
    rst1 = 1'b0; en1 = 1'b0;
  endtask

  task automatic test_hold();
    exp_t e;
    logic exp_y;
    @(negedge clk);
    d1 = 8'hFF; s1 = 3'd0; en1 = 1'b1;
    sb.push_back('{8'h01, 1'b1});
    @(posedge clk);
    #1;
    e = sb.pop_front();
    checks++; if ({7'b0, yq1} !== e.q) begin errors++; $display("FAIL hold_capture_yq: got %b expected %h", yq1, e.q); end
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      en1 = 1'b0;
      d1  = (i % 2 == 0) ? 8'h55 : 8'h0F;
      s1  = 3'(2 * i + 1);
      exp_y = (i == 0) ? 1'b0 : (i == 1) ? 1'b1 : (i == 2) ? 1'b0 : 1'b0;
      #1;
      checks++; if (y1 !== exp_y) begin errors++; $display("FAIL hold_y_track i=%0d: got %b expected %b", i, y1, exp_y); end
      sb.push_back('{8'h01, 1'b1});
      @(posedge clk);
      #1;
      e = sb.pop_front();
      checks++; if ({7'b0, yq1} !== e.q) begin errors++; $display("FAIL hold_yq i=%0d: got %b expected %h", i, yq1, e.q); end
      checks++; if (v1 !== e.v) begin errors++; $display("FAIL hold_valid i=%0d: got %b expected %b", i, v1, e.v); end
    end
  endtask

  task automatic test_random_w4();
    exp_t       e;
    logic [3:0] mq = 4'h0;
    logic       mv = 1'b0;
    logic [3:0] lane;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      s4  = 3'($urandom_range(0, 7));
      d4  = $urandom;
      en4 = 1'($urandom_range(0, 1));
      lane = 4'((d4 >> (4 * s4)) & 32'hF);
      #1;
      checks++; if (y4 !== lane) begin errors++; $display("FAIL rand_y i=%0d: got %h expected %h", i, y4, lane); end
      if (en4) begin
        mq = lane;
        mv = 1'b1;
      end
      sb.push_back('{{4'h0, mq}, mv});
      @(posedge clk);
      #1;
      e = sb.pop_front();
      checks++; if ({4'h0, yq4} !== e.q) begin errors++; $display("FAIL rand_yq i=%0d: got %h expected %h", i, yq4, e.q); end
      checks++; if (v4 !== e.v) begin errors++; $display("FAIL rand_valid i=%0d: got %b expected %b", i, v4, e.v); end
    end
    @(negedge clk);
    en4 = 1'b0;
  endtask

  initial begin
    test_reset();
    test_fa_sum();
    test_fa_carry();
    test_capture_w8();
    test_reset_priority();
    test_hold();
    test_random_w4();
    checks++;
    if (sb.size() != 0) begin
      errors++; $display("FAIL scoreboard_drain: got %0d entries expected 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/multiplexer_8x1.md
Name: multiplexer_8x1

Overview:
- 8-to-1 selector. A 3-bit select s picks one of eight data lanes from packed bus d. The lanes are W bits each, default 1.
- Provides a combinational output y and a registered copy y_q with a valid flag.
- Used as a truth-table element. Example: a full adder is two instances, with d=8'b10010110 for sum and d=8'b11101000 for carry, and s={a,b,cin}.

Parameters:
- W, 1, width of each data lane in bits; legal range 1..64.

Ports:
- clk  input  1  rising-edge clock, used by the registered path only.
- rst  input  1  synchronous, active-high reset.
- s  input  3  lane select; 0 selects the lowest lane.
- d  input  8*W  packed lanes; lane k occupies d[k*W +: W].
- en  input  1  capture strobe for the registered path.
- y  output  W  combinational selected lane.
- y_q  output  W  registered selected lane.
- y_q_valid  output  1  high when y_q holds a capture made since the last reset.

Behaviour:
- Combinational path:
  - y = d[s*W +: W] at all times, with zero latency.
  - y is independent of clk, rst and en; reset does not force y.
  - All 8 select codes are decoded, so there is no default branch and no latch.
  - With W=1: s=0 returns d[0] and s=7 returns d[7].
- Registered path, on the rising edge of clk:
  - If rst: y_q <= 0 and y_q_valid <= 0. Reset has priority over en.
  - Else if en: y_q <= d[s*W +: W] and y_q_valid <= 1. Latency is 1 cycle from the edge at which en is sampled high.
  - Else: y_q and y_q_valid hold.
- Reset mid-operation: if rst and en are high on the same edge, the capture is discarded. y_q=0 and y_q_valid=0 after that edge.
- Capture in back-to-back cycles: each enabled edge captures the current s and d. There is no backpressure and no handshake beyond en.
- Changes on s or d between clock edges affect only y. y_q changes only at clock edges.
- Power-up: y_q and y_q_valid are undefined until the first reset edge. The bench applies rst for at least 1 cycle before checking them.
- Width rules:
  - s is exactly 3 bits, so no out-of-range select exists.
  - Lane k of d maps to select code k; there is no bit reversal.

Decomposition:
- Shared package mux_pkg holds:
  - localparam N_LANES = 8;
  - localparam SEL_W = 3;
  - typedef logic [SEL_W-1:0] sel_t.
- One sub-module is natural: mux_onehot_dec, a 3-to-8 one-hot decoder. Its output ANDs each lane and the results are OR-reduced to form y.
- The register stage stays in the top module.

Test Plan:
- W=1, d=8'b10010110, s swept 0..7 at 10-time-unit steps -> y = 0,1,1,0,1,0,0,1 (full-adder sum).
- W=1, d=8'b11101000, s swept 0..7 -> y = 0,0,0,1,0,1,1,1 (full-adder carry).
- W=8, lane k = 8'hA0+k, s=5, en=1 for one cycle after reset -> y=8'hA5 immediately; y_q=8'hA5 and y_q_valid=1 after 1 edge.
- rst=1 and en=1 on the same edge with d lane 3 = 1, s=3 -> y_q=0 and y_q_valid=0; y=1 throughout.
- After a capture of 1, en=0 while s and d toggle for 4 cycles -> y tracks the inputs; y_q and y_q_valid hold at 1.
- Exhaustive random with W=4: 200 random (s, d, en) vectors -> y matches d[s*4 +: 4] every cycle; y_q matches a reference model delayed by 1 cycle.
